// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline sequencing block:
// FSM encoding, HALT opcode, rs/rt field positions, drain depth.
package pipeline_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check of the IF/ID instruction against ID/EX.
// In: ex_mem_read, ex_rt, id_instruction. Out: stall.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         ex_mem_read,
  input  logic [W-1:0] ex_rt,
  input  logic [B-1:0] id_instruction,
  output logic         stall
);

  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         unused_bits;

  assign rs = id_instruction[RS_MSB:RS_LSB];
  assign rt = id_instruction[RT_MSB:RT_LSB];

  assign unused_bits = ^{id_instruction[B-1:RS_MSB+1],
                         id_instruction[RT_LSB-1:0]};

  // rt is compared for every opcode, even where it is a destination.
  assign stall = ex_mem_read
               && (ex_rt != '0)
               && (ex_rt == rs || ex_rt == rt);

endmodule

// File: rtl/pipeline_control.sv
// Pipeline sequencer: run/step/halt-drain FSM, global enable,
// stall/flush gating and enabled-cycle counter.
// In: clk, reset (sync, low), start, step, id_instruction,
//   ex_mem_read, ex_rt, mem_branch_taken.
// Out: pipe_en, pc_write, ifid_write, ifid_flush, idex_bubble,
//   exmem_flush, halted, cycle_count, state.
module pipeline_control
  import pipeline_pkg::*;
#(
  parameter int B            = 32,
  parameter int W            = 5,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         step,
  input  logic [B-1:0] id_instruction,
  input  logic         ex_mem_read,
  input  logic [W-1:0] ex_rt,
  input  logic         mem_branch_taken,
  output logic         pipe_en,
  output logic         pc_write,
  output logic         ifid_write,
  output logic         ifid_flush,
  output logic         idex_bubble,
  output logic         exmem_flush,
  output logic         halted,
  output logic [B-1:0] cycle_count,
  output logic [2:0]   state
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  state_t        cur, nxt;
  logic          mode_step, mode_nxt;
  logic [CW-1:0] drain_cnt, cnt_nxt;
  logic          step_q, step_rise;
  logic          pe_nxt;
  logic          stall, stall_g, br, drain_en;
  logic          is_halt, halt_go;

  hazard_detect #(.B(B), .W(W)) u_hazard (
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .id_instruction (id_instruction),
    .stall          (stall)
  );

  assign step_rise = step & ~step_q;
  assign is_halt   = (id_instruction == B'(HALT_INSTR));
  assign halt_go   = pipe_en & is_halt & ~mem_branch_taken;

  assign br       = pipe_en & mem_branch_taken;
  assign stall_g  = pipe_en & stall;
  assign drain_en = pipe_en & (cur == DRAIN);

  assign state  = cur;
  assign halted = (cur == HALTED);

  always_comb begin
    nxt      = cur;
    pe_nxt   = 1'b0;
    mode_nxt = mode_step;
    cnt_nxt  = drain_cnt;
    unique case (cur)
      IDLE: begin
        if (start) begin
          nxt    = RUN;
          pe_nxt = 1'b1;
        end else if (step_rise) begin
          nxt    = STEP;
          pe_nxt = 1'b1;
        end
      end
      RUN: begin
        pe_nxt = 1'b1;
        if (halt_go) begin
          nxt      = DRAIN;
          mode_nxt = 1'b0;
          cnt_nxt  = '0;
        end
      end
      STEP: begin
        pe_nxt = step_rise;
        if (halt_go) begin
          nxt      = DRAIN;
          mode_nxt = 1'b1;
          cnt_nxt  = '0;
        end else if (start) begin
          nxt    = RUN;
          pe_nxt = 1'b1;
        end
      end
      DRAIN: begin
        pe_nxt = mode_step ? step_rise : 1'b1;
        if (br) begin
          // HALT was fetched down a mispredicted path.
          cnt_nxt = '0;
          nxt     = mode_step ? STEP : RUN;
        end else if (pipe_en) begin
          if (drain_cnt == CW'(DRAIN_CYCLES - 1)) begin
            nxt     = HALTED;
            pe_nxt  = 1'b0;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = drain_cnt + 1'b1;
          end
        end
      end
      HALTED: pe_nxt = 1'b0;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur         <= IDLE;
      pipe_en     <= 1'b0;
      mode_step   <= 1'b0;
      drain_cnt   <= '0;
      step_q      <= 1'b0;
      cycle_count <= '0;
    end else begin
      cur       <= nxt;
      pipe_en   <= pe_nxt;
      mode_step <= mode_nxt;
      drain_cnt <= cnt_nxt;
      step_q    <= step;
      if (pipe_en)
        cycle_count <= cycle_count + 1'b1;
    end
  end

  // Branch flush outranks stall and drain freeze.
  always_comb begin
    pc_write    = pipe_en;
    ifid_write  = pipe_en;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    if (br) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (stall_g | drain_en) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: driver queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_pipeline_control;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        step;
  logic [31:0] id_instruction;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        mem_branch_taken;
  logic        pipe_en;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        exmem_flush;
  logic        halted;
  logic [31:0] cycle_count;
  logic [2:0]  state;

  pipeline_control dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .step             (step),
    .id_instruction   (id_instruction),
    .ex_mem_read      (ex_mem_read),
    .ex_rt            (ex_rt),
    .mem_branch_taken (mem_branch_taken),
    .pipe_en          (pipe_en),
    .pc_write         (pc_write),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_bubble      (idex_bubble),
    .exmem_flush      (exmem_flush),
    .halted           (halted),
    .cycle_count      (cycle_count),
    .state            (state)
  );

  always #5 clk = ~clk;

  // {pipe_en,pc_write,ifid_write,ifid_flush,idex_bubble,exmem_flush,halted}
  localparam logic [6:0] O_OFF  = 7'b0000000;
  localparam logic [6:0] O_RUN  = 7'b1110000;
  localparam logic [6:0] O_STL  = 7'b1000100;
  localparam logic [6:0] O_BR   = 7'b1111110;
  localparam logic [6:0] O_HLT  = 7'b0000001;
  localparam logic [31:0] NOP   = 32'h0000_0020;
  localparam logic [31:0] HALTI = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [6:0]  o;
    logic [2:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [6:0] o,
                     input state_t st, input int unsigned cnt);
    exp_t e;
    e.o   = o;
    e.st  = st;
    e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cyc(input string nm, input logic [6:0] o,
                     input state_t st, input int unsigned cnt);
    chk(nm, o, st, cnt);
    tick();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g.o   = {pipe_en, pc_write, ifid_write, ifid_flush,
               idex_bubble, exmem_flush, halted};
      g.st  = state;
      g.cnt = cycle_count;
      n_chk++;
      if (g === e) n_pass++;
      else
        $display("FAIL %s: got o=%b st=%0d cnt=%0d, want o=%b st=%0d cnt=%0d",
                 nm, g.o, g.st, g.cnt, e.o, e.st, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; step = 1'b0;
    id_instruction = NOP; ex_mem_read = 1'b0;
    ex_rt = 5'd0; mem_branch_taken = 1'b0;
    tick(); tick();
    cyc("reset", O_OFF, IDLE, 0);

    reset = 1'b1; start = 1'b1;
    cyc("start_req", O_OFF, IDLE, 0);
    start = 1'b0;
    for (int i = 0; i < 10; i++) cyc("run", O_RUN, RUN, i);

    ex_mem_read = 1'b1; ex_rt = 5'd5; id_instruction = 32'h00A7_0000;
    cyc("stall_rs", O_STL, RUN, 10);
    id_instruction = 32'h0065_0000;
    cyc("stall_rt", O_STL, RUN, 11);
    ex_mem_read = 1'b0;
    cyc("no_memread", O_RUN, RUN, 12);
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_instruction = NOP;
    cyc("rt_zero", O_RUN, RUN, 13);
    ex_rt = 5'd5; id_instruction = 32'h00C7_0000;
    cyc("no_match", O_RUN, RUN, 14);
    id_instruction = 32'h00A7_0000; mem_branch_taken = 1'b1;
    cyc("stall_branch", O_BR, RUN, 15);
    ex_mem_read = 1'b0;
    cyc("branch", O_BR, RUN, 16);
    mem_branch_taken = 1'b0; id_instruction = HALTI;
    cyc("halt_seen", O_RUN, RUN, 17);
    for (int i = 0; i < 3; i++) cyc("drain", O_STL, DRAIN, 18 + i);
    cyc("halted", O_HLT, HALTED, 21);
    start = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd31;
    mem_branch_taken = 1'b1;
    cyc("halted_frozen", O_HLT, HALTED, 21);
    start = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    mem_branch_taken = 1'b0; id_instruction = NOP;
    reset = 1'b0;
    cyc("halted_pre_reset", O_HLT, HALTED, 21);
    reset = 1'b1; start = 1'b1;
    cyc("reset_from_halted", O_OFF, IDLE, 0);

    start = 1'b0; id_instruction = HALTI;
    cyc("wp_halt", O_RUN, RUN, 0);
    cyc("wp_drain1", O_STL, DRAIN, 1);
    mem_branch_taken = 1'b1;
    cyc("wp_branch", O_BR, DRAIN, 2);
    mem_branch_taken = 1'b0; id_instruction = NOP;
    cyc("wp_back_run", O_RUN, RUN, 3);

    id_instruction = HALTI;
    cyc("rd_halt", O_RUN, RUN, 4);
    cyc("rd_drain1", O_STL, DRAIN, 5);
    reset = 1'b0;
    cyc("rd_drain2", O_STL, DRAIN, 6);
    reset = 1'b1; id_instruction = NOP;
    cyc("rd_idle", O_OFF, IDLE, 0);

    step = 1'b1;
    cyc("sh_req", O_OFF, IDLE, 0);
    cyc("sh_grant", O_RUN, STEP, 0);
    for (int i = 0; i < 3; i++) cyc("sh_hold", O_OFF, STEP, 1);
    step = 1'b0;
    cyc("sh_release", O_OFF, STEP, 1);
    reset = 1'b0;
    cyc("sp_reset", O_OFF, STEP, 1);
    reset = 1'b1;
    cyc("sp_idle", O_OFF, IDLE, 0);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      cyc("sp_rise", O_OFF, (p == 0) ? IDLE : STEP, p);
      step = 1'b0;
      cyc("sp_grant", O_RUN, STEP, p);
      cyc("sp_wait", O_OFF, STEP, p + 1);
    end

    id_instruction = HALTI; step = 1'b1;
    cyc("sd_rise", O_OFF, STEP, 3);
    step = 1'b0;
    cyc("sd_halt", O_RUN, STEP, 3);
    cyc("sd_frozen", O_OFF, DRAIN, 4);
    step = 1'b1;
    cyc("sd_rise2", O_OFF, DRAIN, 4);
    step = 1'b0;
    cyc("sd_drain", O_STL, DRAIN, 4);
    cyc("sd_frozen2", O_OFF, DRAIN, 5);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_queue: got %0d left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central sequencing block for the five-stage MIPS pipeline. It gates every pipeline register through a global enable and supports continuous run, single-step and halt-with-drain operation. It detects load-use hazards against the instruction currently in IF/ID and generates the stall and flush controls around the decode stage. It also counts executed cycles for the debug unit.

## Interface
- B, 32, instruction / counter width
- W, 5, register address width
- DRAIN_CYCLES, 3, enabled cycles needed to retire the instructions ahead of a HALT (EX, MEM, WB)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; reset=0 at a rising edge resets all state
- start  in  1  level; requests continuous run
- step  in  1  single-step request; internally rising-edge detected
- id_instruction  in  B  instruction held in IF/ID
- ex_mem_read  in  1  MemRead of the instruction in ID/EX
- ex_rt  in  W  rt field of the instruction in ID/EX
- mem_branch_taken  in  1  branch in MEM resolved taken
- pipe_en  out  1  global enable for PC and all pipeline registers
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  force all ID/EX control signals to 0
- exmem_flush  out  1  clear EX/MEM control signals
- halted  out  1  pipeline drained after HALT
- cycle_count  out  B  number of enabled cycles since reset
- state  out  3  current FSM state, for debug readout

## Operation
- FSM states: IDLE, RUN, STEP, DRAIN, HALTED. A mode flag records whether DRAIN was entered from RUN or from STEP.
- IDLE goes to RUN on start=1. IDLE goes to STEP on a rising edge of step. If start and a step edge arrive in the same cycle, start wins.
- RUN: pipe_en=1 every cycle.
- STEP: pipe_en=1 for exactly one cycle per step rising edge; a held step gives one enabled cycle only. start=1 in STEP moves to RUN.
- HALT instruction is 32'hFFFF_FFFF.
- HALT in id_instruction during an enabled cycle, with mem_branch_taken=0, moves the FSM to DRAIN.
  - In DRAIN: pc_write=0, ifid_write=0 and idex_bubble=1 on every enabled cycle.
  - An internal counter counts enabled DRAIN cycles; after DRAIN_CYCLES of them the FSM moves to HALTED.
  - DRAIN honours the saved mode: in RUN mode every cycle is enabled; in STEP mode only step-granted cycles are enabled.
- mem_branch_taken=1 during DRAIN means the HALT was on the wrong path. The flush outputs assert, the drain counter clears, and the FSM returns to the saved mode.
- HALTED: pipe_en=0 and halted=1. Only reset leaves HALTED.
- Load-use stall = ex_mem_read AND ex_rt≠0 AND (ex_rt==id_instruction[25:21] OR ex_rt==id_instruction[20:16]). The rt field is compared for every opcode (conservative).
  - On stall: pc_write=0, ifid_write=0, idex_bubble=1.
- Branch taken (mem_branch_taken=1): ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1. This overrides the stall and the HALT detection in the same cycle.
- When no hazard and no flush: pc_write=ifid_write=pipe_en, and all flush/bubble outputs are 0.
- All hazard and flush outputs are ANDed with pipe_en. They are never asserted on a frozen cycle.
- cycle_count increments on every cycle with pipe_en=1 and wraps modulo 2^B.

## Timing
- Reset values: state=IDLE, pipe_en=0, pc_write=0, ifid_write=0, all flush/bubble outputs 0, halted=0, cycle_count=0, mode=RUN, drain counter=0, step edge register=0.
- start sampled high at edge N: pipe_en=1 from cycle N+1.
- Rising edge of step sampled at edge N: pipe_en=1 during cycle N+1 only.
- pipe_en, halted and state are registered from the FSM.
- pc_write, ifid_write, ifid_flush, idex_bubble and exmem_flush are combinational from the inputs and pipe_en, so they take effect in the same cycle.
- HALT seen on enabled cycle N: state=DRAIN from N+1. In RUN, halted=1 and pipe_en=0 from N+1+DRAIN_CYCLES.
- reset asserted mid-operation (any state) returns to IDLE at the next edge, regardless of other inputs.

## Structure
- Shared package pipeline_pkg holds:
  - state encoding constants: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4
  - HALT_INSTR
  - rs/rt field bit positions
  - DRAIN_CYCLES default
- One combinational sub-module, hazard_detect, takes ex_mem_read, ex_rt and id_instruction and outputs stall. The FSM, counters and output gating stay in pipeline_control.

## Test plan
- Reset, then start=1 -> pipe_en=1 from the next cycle; after 10 cycles cycle_count=10.
- ex_mem_read=1, ex_rt=5, id_instruction rs=5 -> pc_write=0, ifid_write=0, idex_bubble=1. With ex_rt=0 and rs=0 -> no stall.
- Stall conditions and mem_branch_taken=1 in the same cycle -> pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1.
- RUN, id_instruction=32'hFFFF_FFFF -> DRAIN for 3 cycles, then halted=1, pipe_en=0, and cycle_count stops. mem_branch_taken=1 on the second DRAIN cycle instead -> flushes assert, state returns to RUN, halted stays 0.
- IDLE, step held high 5 cycles -> exactly one enabled cycle and cycle_count=1. Three separate step pulses -> cycle_count=3.
- reset=0 while in DRAIN mid-count -> next cycle state=IDLE, all outputs at their reset values.
